duty_slew: RTL and testbench

Slew-rate limiter between the gesture/switch decode and a `pwm` servo channel: takes a target duty word and walks the delivered duty toward it by a fixed step once per servo period. Prevents full-scale jumps (e.g. 50000 to 145000) from reaching the servo in a single frame. One instance per servo channel, with `duty_out` driving the matching `pwm.duty_in`.

---
 rtl/duty_slew_pkg.sv | 27 ++
 rtl/duty_slew_frame_tick.sv | 52 +++++
 rtl/duty_slew.sv | 144 ++++++++++++++
 tb/tb_duty_slew.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_slew_pkg.sv
// duty_slew_pkg: constants and types shared by the servo slew limiter, the
// gesture/switch decode table and the pwm channel.
//
// Contents:
//   DUTY_W           duty word width (matches pwm.duty_in)
//   SERVO_*_DUTY     servo duty endpoints and neutral, in clocks
//   DEF_PERIOD       default servo frame length in clocks (20 ms at 100 MHz)
//   DEF_STEP         default maximum duty change per frame, in clocks
//   slew_state_e     slew direction state (IDLE / UP / DOWN)
package duty_slew_pkg;

  localparam int unsigned DUTY_W          = 26;

  localparam int unsigned SERVO_MIN_DUTY  = 50000;
  localparam int unsigned SERVO_INIT_DUTY = 97500;
  localparam int unsigned SERVO_MAX_DUTY  = 145000;

  localparam int unsigned DEF_PERIOD      = 2000000;
  localparam int unsigned DEF_STEP        = 2500;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // duty == target
    ST_UP   = 2'd1,  // duty <  target
    ST_DOWN = 2'd2   // duty >  target
  } slew_state_e;

endpackage

// File: rtl/duty_slew_frame_tick.sv
// frame_tick: free-running servo frame counter.
//
// The counter runs 0..PERIOD-1 and wraps. tick_o is high in the last cycle of
// each frame; period_start_o is a registered one-cycle pulse in the first
// cycle of the next frame (counter == 0). Reusable to align other channels.
//
// Parameters:
//   PERIOD          clocks per frame (>= 2)
// Ports:
//   clk             system clock
//   rst_n           synchronous active-low reset
//   tick_o          high while the counter is at PERIOD-1
//   period_start_o  registered pulse on the first cycle of each frame
module frame_tick
  import duty_slew_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o,
  output logic period_start_o
);

  localparam int unsigned    CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             period_start_q;

  assign tick_o         = (cnt_q == CNT_LAST);
  assign period_start_o = period_start_q;

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // only takes effect at an edge; every flop here is plain state, no RAM.
    if (!rst_n) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop samples pre-edge values regardless of
      // statement order.
      cnt_q          <= cnt_d;
      period_start_q <= tick_o;
    end
  end

endmodule

// File: rtl/duty_slew.sv
// duty_slew: slew-rate limiter for one servo pwm channel.
//
// Walks duty_out toward the most recently loaded target by at most STEP per
// servo frame, so full-scale target jumps reach the servo as a ramp.
// duty_out only changes at the frame boundary and is first visible together
// with period_start.
//
// Build option:
//   DUTY_SLEW_CLAMP_EN  when defined, loaded targets are saturated to
//                       [MIN_DUTY, MAX_DUTY]; otherwise passed unmodified.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   target_in     requested duty, sampled when target_load = 1
//   target_load   load strobe (may be held; sampled every cycle)
//   duty_out      registered duty delivered to pwm.duty_in
//   period_start  one-cycle pulse on the first cycle of each frame
//   busy          registered, high while duty_out != target
//   settled       one-cycle pulse when a ramp lands exactly on target
module duty_slew
  import duty_slew_pkg::*;
#(
  parameter int unsigned WIDTH     = DUTY_W,
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned STEP      = DEF_STEP,
  parameter int unsigned INIT_DUTY = SERVO_INIT_DUTY,
  parameter int unsigned MIN_DUTY  = SERVO_MIN_DUTY,
  parameter int unsigned MAX_DUTY  = SERVO_MAX_DUTY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] target_in,
  input  logic             target_load,
  output logic [WIDTH-1:0] duty_out,
  output logic             period_start,
  output logic             busy,
  output logic             settled
);

  localparam logic [WIDTH-1:0] INIT_W   = WIDTH'(INIT_DUTY);
  localparam logic [WIDTH-1:0] STEP_N   = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);

  if (MIN_DUTY > MAX_DUTY) begin : g_bad_clamp_range
    $error("duty_slew: MIN_DUTY must not exceed MAX_DUTY");
  end

  slew_state_e      state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             busy_q, busy_d;
  logic             settled_q, settled_d;
  logic [WIDTH-1:0] target_eff;
  logic [WIDTH:0]   diff;
  logic             tick;

  frame_tick #(
    .PERIOD(PERIOD)
  ) u_frame_tick (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_o        (tick),
    .period_start_o(period_start)
  );

`ifdef DUTY_SLEW_CLAMP_EN
  always_comb begin
    if (target_in < WIDTH'(MIN_DUTY)) begin
      target_eff = WIDTH'(MIN_DUTY);
    end else if (target_in > WIDTH'(MAX_DUTY)) begin
      target_eff = WIDTH'(MAX_DUTY);
    end else begin
      target_eff = target_in;
    end
  end
`else
  assign target_eff = target_in;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d   = state_q;
    target_d  = target_q;
    duty_d    = duty_q;
    settled_d = 1'b0;
    diff      = '0;

    if (target_load) begin
      // A load wins over a coincident tick: duty holds, direction is
      // re-derived from the new target against the current duty.
      target_d = target_eff;
      if (target_eff > duty_q) begin
        state_d = ST_UP;
      end else if (target_eff < duty_q) begin
        state_d = ST_DOWN;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (tick && (state_q != ST_IDLE)) begin
      // The state already tells which operand is larger, so the
      // subtraction cannot wrap.
      if (state_q == ST_UP) begin
        diff = {1'b0, target_q} - {1'b0, duty_q};
      end else begin
        diff = {1'b0, duty_q} - {1'b0, target_q};
      end

      if (diff <= STEP_EXT) begin
        duty_d    = target_q;
        state_d   = ST_IDLE;
        settled_d = 1'b1;
      end else if (state_q == ST_UP) begin
        duty_d = duty_q + STEP_N;
      end else begin
        duty_d = duty_q - STEP_N;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      target_q  <= INIT_W;
      duty_q    <= INIT_W;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      duty_q    <= duty_d;
      busy_q    <= busy_d;
      settled_q <= settled_d;
    end
  end

  assign duty_out = duty_q;
  assign busy     = busy_q;
  assign settled  = settled_q;

endmodule

// File: tb/tb_duty_slew.sv
// tb_duty_slew: self-checking bench for duty_slew with small parameters
// (PERIOD=10, STEP=100, INIT=1000, MIN=500, MAX=2000).
//
// A reference model tracks the frame phase, the target and the delivered duty
// from the behavioural rules alone (each frame the duty moves toward the
// target by at most STEP). Inputs change on the falling edge; outputs and
// model are compared on the falling edge.
// Honours DUTY_SLEW_CLAMP_EN for the expected target saturation.
module tb_duty_slew;

  localparam int W    = 26;
  localparam int P    = 10;
  localparam int S    = 100;
  localparam int INIT = 1000;
  localparam int MN   = 500;
  localparam int MX   = 2000;

  logic         clk         = 1'b0;
  logic         rst_n       = 1'b0;
  logic         target_load = 1'b0;
  logic [W-1:0] target_in   = '0;
  logic [W-1:0] duty_out;
  logic         period_start;
  logic         busy;
  logic         settled;

  int errors = 0;
  int checks = 0;

  // Reference model state, values valid after each rising edge.
  int m_cnt     = 0;
  int m_duty    = INIT;
  int m_target  = INIT;
  bit m_busy    = 1'b0;
  bit m_settled = 1'b0;
  bit m_ps      = 1'b0;
  int m_dist;

  duty_slew #(
    .WIDTH    (W),
    .PERIOD   (P),
    .STEP     (S),
    .INIT_DUTY(INIT),
    .MIN_DUTY (MN),
    .MAX_DUTY (MX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .target_in   (target_in),
    .target_load (target_load),
    .duty_out    (duty_out),
    .period_start(period_start),
    .busy        (busy),
    .settled     (settled)
  );

  always #5 clk = ~clk;

  function automatic int clamp_ref(input int t);
`ifdef DUTY_SLEW_CLAMP_EN
    if (t < MN) return MN;
    if (t > MX) return MX;
    return t;
`else
    return t;
`endif
  endfunction

  // Behavioural model: at each frame boundary the duty approaches the target
  // by min(STEP, distance); a load that cycle suppresses the move.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt     = 0;
      m_duty    = INIT;
      m_target  = INIT;
      m_busy    = 1'b0;
      m_settled = 1'b0;
      m_ps      = 1'b0;
    end else begin
      m_settled = 1'b0;
      m_ps      = (m_cnt == P - 1);
      if (target_load) begin
        m_target = clamp_ref(int'(target_in));
      end else if (m_ps && (m_duty != m_target)) begin
        m_dist = (m_target > m_duty) ? m_target - m_duty : m_duty - m_target;
        if (m_dist <= S) begin
          m_duty    = m_target;
          m_settled = 1'b1;
        end else begin
          m_duty = (m_target > m_duty) ? m_duty + S : m_duty - S;
        end
      end
      m_busy = (m_duty != m_target);
      m_cnt  = (m_cnt + 1) % P;
    end
  end

  task automatic test_reset();
    int first_ps;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (duty_out !== W'(INIT) || busy !== 1'b0 || settled !== 1'b0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: duty=%0d busy=%b settled=%b ps=%b, expected duty=%0d busy=0 settled=0 ps=0",
               duty_out, busy, settled, period_start, INIT);
    end
    rst_n    = 1'b1;
    first_ps = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (period_start === 1'b1 && first_ps < 0) first_ps = i;
      checks++;
      if (duty_out !== W'(INIT) || busy !== 1'b0 || period_start !== m_ps) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: duty=%0d busy=%b ps=%b, expected duty=%0d busy=0 ps=%b",
                 i, duty_out, busy, period_start, INIT, m_ps);
      end
    end
    checks++;
    if (first_ps != 10) begin
      errors++;
      $display("FAIL first_period_start: got cycle %0d, expected cycle 10", first_ps);
    end
  endtask

  task automatic test_ramp_up();
    int exp_duty[4] = '{1100, 1200, 1300, 1350};
    int frame = 0;
    for (int i = 0; i < P && m_cnt != 3; i++) @(negedge clk);
    target_in   = W'(1350);
    target_load = 1'b1;
    @(negedge clk);
    target_load = 1'b0;
    checks++;
    if (busy !== 1'b1 || duty_out !== W'(INIT)) begin
      errors++;
      $display("FAIL ramp_busy_rise: busy=%b duty=%0d, expected busy=1 duty=%0d", busy, duty_out, INIT);
    end
    for (int i = 0; i < 5 * P && frame < 4; i++) begin
      @(negedge clk);
      checks++;
      if (duty_out !== W'(m_duty) || busy !== m_busy || settled !== m_settled || period_start !== m_ps) begin
        errors++;
        $display("FAIL ramp_model: duty=%0d busy=%b settled=%b ps=%b, expected duty=%0d busy=%b settled=%b ps=%b",
                 duty_out, busy, settled, period_start, m_duty, m_busy, m_settled, m_ps);
      end
      if (period_start === 1'b1) begin
        checks++;
        if (duty_out !== W'(exp_duty[frame]) || settled !== (frame == 3) || busy !== (frame != 3)) begin
          errors++;
          $display("FAIL ramp_frame%0d: duty=%0d settled=%b busy=%b, expected duty=%0d settled=%b busy=%b",
                   frame, duty_out, settled, busy, exp_duty[frame], frame == 3, frame != 3);
        end
        frame++;
      end
    end
    checks++;
    if (frame != 4) begin
      errors++;
      $display("FAIL ramp_timeout: saw %0d frames, expected 4", frame);
    end
  endtask

  task automatic test_retarget();
    bit hit;
    int frame;
    int exp_duty[2] = '{1100, 1000};
    // Return to 1000, then ramp toward 1350 and stop it at 1200.
    target_in   = W'(1000);
    target_load = 1'b1;
    @(negedge clk);
    target_load = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 6 * P && !hit; i++) begin
      @(negedge clk);
      if (settled === 1'b1) hit = 1'b1;
    end
    target_in   = W'(1350);
    target_load = 1'b1;
    @(negedge clk);
    target_load = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 4 * P && !hit; i++) begin
      @(negedge clk);
      if (period_start === 1'b1 && duty_out === W'(1200)) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL retarget_reach_1200: duty=%0d, expected 1200 within 4 frames", duty_out);
    end
    target_in   = W'(1000);
    target_load = 1'b1;
    @(negedge clk);
    target_load = 1'b0;
    checks++;
    if (busy !== 1'b1 || duty_out !== W'(1200)) begin
      errors++;
      $display("FAIL retarget_down_state: busy=%b duty=%0d, expected busy=1 duty=1200", busy, duty_out);
    end
    frame = 0;
    for (int i = 0; i < 3 * P && frame < 2; i++) begin
      @(negedge clk);
      checks++;
      if (duty_out > W'(1200) || duty_out < W'(1000)) begin
        errors++;
        $display("FAIL retarget_overshoot: duty=%0d, expected within 1000..1200", duty_out);
      end
      if (period_start === 1'b1) begin
        checks++;
        if (duty_out !== W'(exp_duty[frame]) || settled !== (frame == 1)) begin
          errors++;
          $display("FAIL retarget_frame%0d: duty=%0d settled=%b, expected duty=%0d settled=%b",
                   frame, duty_out, settled, exp_duty[frame], frame == 1);
        end
        frame++;
      end
    end
    checks++;
    if (frame != 2) begin
      errors++;
      $display("FAIL retarget_timeout: saw %0d frames, expected 2", frame);
    end
  endtask

  task automatic test_load_on_tick();
    int frame;
    int exp_duty[4] = '{1000, 1100, 1200, 1300};
    for (int i = 0; i < P && m_cnt != P - 1; i++) @(negedge clk);
    target_in   = W'(1500);
    target_load = 1'b1;
    @(negedge clk);
    target_load = 1'b0;
    // This cycle is the first of the new frame; the step was skipped.
    checks++;
    if (period_start !== 1'b1 || duty_out !== W'(1000) || busy !== 1'b1) begin
      errors++;
      $display("FAIL tick_load_first: ps=%b duty=%0d busy=%b, expected ps=1 duty=1000 busy=1",
               period_start, duty_out, busy);
    end
    frame = 1;
    for (int i = 0; i < 4 * P && frame < 4; i++) begin
      @(negedge clk);
      checks++;
      if (duty_out !== W'(m_duty) || busy !== m_busy || settled !== m_settled || period_start !== m_ps) begin
        errors++;
        $display("FAIL tick_load_model: duty=%0d busy=%b settled=%b ps=%b, expected duty=%0d busy=%b settled=%b ps=%b",
                 duty_out, busy, settled, period_start, m_duty, m_busy, m_settled, m_ps);
      end
      if (period_start === 1'b1) begin
        checks++;
        if (duty_out !== W'(exp_duty[frame])) begin
          errors++;
          $display("FAIL tick_load_frame%0d: duty=%0d, expected %0d", frame, duty_out, exp_duty[frame]);
        end
        frame++;
      end
    end
    checks++;
    if (frame != 4) begin
      errors++;
      $display("FAIL tick_load_timeout: saw %0d frames, expected 4", frame);
    end
  endtask

  // Entered at the cycle where duty_out has just become 1300 on its way to 1500.
  task automatic test_reset_mid_ramp();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (duty_out !== W'(INIT) || busy !== 1'b0 || period_start !== 1'b0 || settled !== 1'b0) begin
      errors++;
      $display("FAIL midramp_reset: duty=%0d busy=%b ps=%b settled=%b, expected duty=%0d busy=0 ps=0 settled=0",
               duty_out, busy, period_start, settled, INIT);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      checks++;
      if (duty_out !== W'(INIT) || busy !== 1'b0 || settled !== 1'b0) begin
        errors++;
        $display("FAIL midramp_target_reset: duty=%0d busy=%b settled=%b, expected duty=%0d busy=0 settled=0",
                 duty_out, busy, settled, INIT);
      end
    end
  endtask

  task automatic test_clamp();
    int exp_final = clamp_ref(3000);
    int exp_frames = (exp_final - INIT + S - 1) / S;
    int frames = 0;
    bit done = 1'b0;
    target_in   = W'(3000);
    target_load = 1'b1;
    @(negedge clk);
    target_load = 1'b0;
    for (int i = 0; i < 30 * P && !done; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) frames++;
      if (settled === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done || duty_out !== W'(exp_final) || busy !== 1'b0) begin
      errors++;
      $display("FAIL clamp_final: done=%b duty=%0d busy=%b, expected done=1 duty=%0d busy=0",
               done, duty_out, busy, exp_final);
    end
    checks++;
    if (frames != exp_frames) begin
      errors++;
      $display("FAIL clamp_ramp_frames: got %0d, expected %0d", frames, exp_frames);
    end
  endtask

  task automatic test_random();
    int prev = int'(duty_out);
    int delta;
    for (int i = 0; i < 1500; i++) begin
      if (target_load && $urandom_range(0, 2) == 0) begin
        target_in = W'($urandom_range(0, 4000));
      end else if ($urandom_range(0, 24) == 0) begin
        target_in   = W'($urandom_range(0, 4000));
        target_load = 1'b1;
      end else begin
        target_load = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (duty_out !== W'(m_duty) || busy !== m_busy || settled !== m_settled || period_start !== m_ps) begin
        errors++;
        $display("FAIL random_model cycle %0d: duty=%0d busy=%b settled=%b ps=%b, expected duty=%0d busy=%b settled=%b ps=%b",
                 i, duty_out, busy, settled, period_start, m_duty, m_busy, m_settled, m_ps);
      end
      delta = int'(duty_out) - prev;
      checks++;
      if (delta > S || delta < -S || (delta != 0 && period_start !== 1'b1)) begin
        errors++;
        $display("FAIL random_slew cycle %0d: change=%0d ps=%b, expected |change|<=%0d only at frame start",
                 i, delta, period_start, S);
      end
      prev = int'(duty_out);
    end
    target_load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_retarget();
    test_load_on_tick();
    test_reset_mid_ramp();
    test_clamp();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
